// File: rtl/ser_stream.sv
// Parallel-to-serial streamer with valid/ready intake, a one-word holding buffer and a last-bit marker.
// Define SER_STREAM_PARITY_EN to append an even-parity bit after each word's data bits.
module ser_stream #(
    parameter int WIDTH   = 16,
    parameter int MOD_W   = $clog2(WIDTH),
    parameter int MIN_LEN = 3
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [MOD_W-1:0] data_mod_i,
    input  logic             lsb_first_i,
    input  logic             data_val_i,
    output logic             ready_o,
    output logic             ser_data_o,
    output logic             ser_data_val_o,
    output logic             ser_last_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef SER_STREAM_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
`endif

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sh_reg, sh_next;
    logic             lsb_reg, lsb_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             hold_valid_reg, hold_valid_next;
    logic [WIDTH-1:0] hold_data_reg, hold_data_next;
    logic [CW-1:0]    hold_len_reg, hold_len_next;
    logic             hold_lsb_reg, hold_lsb_next;
    logic             ser_data_reg, ser_data_next;
    logic             ser_val_reg, ser_val_next;
    logic             ser_last_reg, ser_last_next;
    logic             busy_reg, busy_next;
`ifdef SER_STREAM_PARITY_EN
    logic             par_reg, par_next;
`endif

    logic [CW-1:0]    in_len;
    logic             in_ok;
    logic             shifter_free;
    logic             do_load;
    logic [WIDTH-1:0] ld_data;
    logic [CW-1:0]    ld_len;
    logic             ld_lsb;
    logic             ld_bit;
    logic             nx_bit;

    assign ready_o        = !hold_valid_reg;
    assign ser_data_o     = ser_data_reg;
    assign ser_data_val_o = ser_val_reg;
    assign ser_last_o     = ser_last_reg;
    assign busy_o         = busy_reg;

    // Words with an out-of-range modifier or below the minimum length are swallowed here.
    assign in_len = (data_mod_i == '0) ? CW'(WIDTH) : CW'(data_mod_i);
    assign in_ok  = data_val_i && ready_o
                    && (int'(data_mod_i) <= WIDTH)
                    && (int'(in_len) >= MIN_LEN);

    // The shifter can take a new word while idle or while its final output cycle is on the line.
`ifdef SER_STREAM_PARITY_EN
    assign shifter_free = (state_reg == ST_IDLE) || (state_reg == ST_PARITY);
`else
    assign shifter_free = (state_reg == ST_IDLE)
                          || ((state_reg == ST_SHIFT) && (cnt_reg == '0));
`endif

    always_comb begin
        state_next      = state_reg;
        sh_next         = sh_reg;
        lsb_next        = lsb_reg;
        cnt_next        = cnt_reg;
        hold_valid_next = hold_valid_reg;
        hold_data_next  = hold_data_reg;
        hold_len_next   = hold_len_reg;
        hold_lsb_next   = hold_lsb_reg;
        ser_data_next   = 1'b0;
        ser_val_next    = 1'b0;
        ser_last_next   = 1'b0;
`ifdef SER_STREAM_PARITY_EN
        par_next        = par_reg;
`endif
        do_load         = 1'b0;
        ld_data         = hold_data_reg;
        ld_len          = hold_len_reg;
        ld_lsb          = hold_lsb_reg;

        // The buffered word always has priority so ordering is preserved.
        if (hold_valid_reg && shifter_free) begin
            do_load         = 1'b1;
            hold_valid_next = 1'b0;
        end else if (in_ok && shifter_free) begin
            do_load = 1'b1;
            ld_data = data_i;
            ld_len  = in_len;
            ld_lsb  = lsb_first_i;
        end else if (in_ok) begin
            hold_valid_next = 1'b1;
            hold_data_next  = data_i;
            hold_len_next   = in_len;
            hold_lsb_next   = lsb_first_i;
        end

        ld_bit = ld_lsb ? ld_data[0] : ld_data[WIDTH-1];
        nx_bit = lsb_reg ? sh_reg[0] : sh_reg[WIDTH-1];

        if (do_load) begin
            state_next    = ST_SHIFT;
            ser_val_next  = 1'b1;
            ser_data_next = ld_bit;
            sh_next       = ld_lsb ? (ld_data >> 1) : (ld_data << 1);
            lsb_next      = ld_lsb;
            cnt_next      = ld_len - CW'(1);
`ifdef SER_STREAM_PARITY_EN
            par_next      = ld_bit;
`else
            ser_last_next = (ld_len == CW'(1));
`endif
        end else begin
            case (state_reg)
                ST_SHIFT: begin
                    if (cnt_reg != '0) begin
                        ser_val_next  = 1'b1;
                        ser_data_next = nx_bit;
                        sh_next       = lsb_reg ? (sh_reg >> 1) : (sh_reg << 1);
                        cnt_next      = cnt_reg - CW'(1);
`ifdef SER_STREAM_PARITY_EN
                        par_next      = par_reg ^ nx_bit;
`else
                        ser_last_next = (cnt_reg == CW'(1));
`endif
                    end else begin
`ifdef SER_STREAM_PARITY_EN
                        state_next    = ST_PARITY;
                        ser_val_next  = 1'b1;
                        ser_data_next = par_reg;
                        ser_last_next = 1'b1;
`else
                        state_next    = ST_IDLE;
`endif
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        busy_next = (state_next != ST_IDLE) || hold_valid_next;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_reg      <= ST_IDLE;
            sh_reg         <= '0;
            lsb_reg        <= 1'b0;
            cnt_reg        <= '0;
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
            hold_len_reg   <= '0;
            hold_lsb_reg   <= 1'b0;
            ser_data_reg   <= 1'b0;
            ser_val_reg    <= 1'b0;
            ser_last_reg   <= 1'b0;
            busy_reg       <= 1'b0;
`ifdef SER_STREAM_PARITY_EN
            par_reg        <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            sh_reg         <= sh_next;
            lsb_reg        <= lsb_next;
            cnt_reg        <= cnt_next;
            hold_valid_reg <= hold_valid_next;
            hold_data_reg  <= hold_data_next;
            hold_len_reg   <= hold_len_next;
            hold_lsb_reg   <= hold_lsb_next;
            ser_data_reg   <= ser_data_next;
            ser_val_reg    <= ser_val_next;
            ser_last_reg   <= ser_last_next;
            busy_reg       <= busy_next;
`ifdef SER_STREAM_PARITY_EN
            par_reg        <= par_next;
`endif
        end
    end

endmodule

// File: tb/tb_ser_stream.sv
// Scoreboard bench for ser_stream: expected {bit,last} pairs are queued at handshake and popped per valid output cycle.
module tb_ser_stream;

    logic        clk = 1'b0;
    logic        srst_i;
    logic [15:0] data_i;
    logic [3:0]  data_mod_i;
    logic        lsb_first_i;
    logic        data_val_i;
    logic        ready_o;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        ser_last_o;
    logic        busy_o;

    ser_stream #(.WIDTH(16), .MIN_LEN(3)) dut (
        .clk_i          (clk),
        .srst_i         (srst_i),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .lsb_first_i    (lsb_first_i),
        .data_val_i     (data_val_i),
        .ready_o        (ready_o),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .ser_last_o     (ser_last_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int run_len  = 0;
    int max_run  = 0;
    int words_out = 0;
    bit saw_not_ready;
    logic [1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference serialisation of one word.
    task automatic push_word(input logic [15:0] d, input int m, input bit l);
        int  len;
        bit  b;
        bit  par;
        len = (m == 0) ? 16 : m;
        par = 1'b0;
        $display("accept data=%04h mod=%0d lsb_first=%0d len=%0d%s", d, m, l, len,
                 (len < 3) ? " (dropped)" : "");
        if (len >= 3) begin
            for (int k = 0; k < len; k++) begin
                b   = l ? d[k] : d[15-k];
                par = par ^ b;
`ifdef SER_STREAM_PARITY_EN
                exp_q.push_back({b, 1'b0});
`else
                exp_q.push_back({b, (k == len - 1) ? 1'b1 : 1'b0});
`endif
            end
`ifdef SER_STREAM_PARITY_EN
            exp_q.push_back({par, 1'b1});
`endif
        end
    endtask

    // Called at a negedge; returns at the negedge following the handshake edge.
    task automatic send(input logic [15:0] d, input int m, input bit l, input bit keep_valid);
        int t;
        t = 0;
        data_i      = d;
        data_mod_i  = 4'(m);
        lsb_first_i = l;
        data_val_i  = 1'b1;
        while (!ready_o && t < 100) begin
            saw_not_ready = 1'b1;
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("ready_timeout", 32'd0, 32'd1);
        push_word(d, m, l);
        @(negedge clk);
        if (!keep_valid) data_val_i = 1'b0;
    endtask

    task automatic drain_and_check_busy();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("busy_fall", {31'd0, busy_o}, 32'd0);
        chk("val_fall", {31'd0, ser_data_val_o}, 32'd0);
    endtask

    always @(negedge clk) begin
        logic [1:0] e;
        if (!srst_i) begin
            if (ser_data_val_o) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ser_data", {31'd0, ser_data_o}, {31'd0, e[1]});
                    chk("ser_last", {31'd0, ser_last_o}, {31'd0, e[0]});
                    if (ser_last_o) begin
                        words_out++;
                        $display("word %0d complete at %0t", words_out, $time);
                    end
                end
            end else begin
                run_len = 0;
                chk("idle_zero", {30'd0, ser_data_o, ser_last_o}, 32'd0);
            end
        end
    end

    initial begin
        srst_i      = 1'b1;
        data_i      = '0;
        data_mod_i  = '0;
        lsb_first_i = 1'b0;
        data_val_i  = 1'b0;
        repeat (3) @(negedge clk);
        srst_i = 1'b0;
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_val", {31'd0, ser_data_val_o}, 32'd0);

        // Full-width MSB-first word.
        send(16'hA5C3, 0, 1'b0, 1'b0);
        chk("busy_rise", {31'd0, busy_o}, 32'd1);
        drain_and_check_busy();

        // Short word, both bit orders.
        send(16'h00B4, 5, 1'b1, 1'b0);
        drain_and_check_busy();
        send(16'h00B4, 5, 1'b0, 1'b0);
        drain_and_check_busy();

        // Back-to-back with valid held high.
        max_run = 0;
        saw_not_ready = 1'b0;
        send(16'h9000, 4, 1'b0, 1'b1);
        send(16'h0005, 3, 1'b1, 1'b1);
        send(16'hB400, 6, 1'b0, 1'b0);
        drain_and_check_busy();
        chk("ready_drop", {31'd0, saw_not_ready}, 32'd1);
        chk("contig_run", 32'(max_run), 32'd13);

        // Below minimum length: consumed, no output.
        send(16'hFFFF, 2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("short_busy", {31'd0, busy_o}, 32'd0);
            chk("short_ready", {31'd0, ready_o}, 32'd1);
            @(negedge clk);
        end

        // Reset mid-word with a buffered word.
        send(16'hFFFF, 0, 1'b0, 1'b0);
        send(16'hFFFF, 0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("pre_rst_ready", {31'd0, ready_o}, 32'd0);
        srst_i = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk("mid_rst_outs", {28'd0, ser_data_o, ser_data_val_o, ser_last_o, busy_o}, 32'd0);
        chk("mid_rst_ready", {31'd0, ready_o}, 32'd1);
        srst_i = 1'b0;
        send(16'h4001, 0, 1'b0, 1'b0);
        drain_and_check_busy();

`ifdef SER_STREAM_PARITY_EN
        send(16'hF000, 4, 1'b0, 1'b0);
        drain_and_check_busy();
`endif

        chk("word_count_nonzero", {31'd0, (words_out >= 6) ? 1'b1 : 1'b0}, 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ser_stream.md
Name: ser_stream

Overview:
- Parametrised successor of the locking serializer: converts parallel words of variable valid length into a serial bit stream.
- Adds a valid/ready handshake, a one-word holding buffer for gapless back-to-back transfers, per-word bit-order selection, full-width encoding and a last-bit marker.
- Sits between the parallel data source and the serial line driver.

Parameters:
- WIDTH, 16, parallel word width in bits (>= 2).
- MOD_W, $clog2(WIDTH), width of the length modifier.
- MIN_LEN, 3, minimum accepted length; shorter words are dropped.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- srst_i  input  1  synchronous reset, active-high.
- data_i  input  WIDTH  parallel word.
- data_mod_i  input  MOD_W  bit count; 0 encodes WIDTH.
- lsb_first_i  input  1  per-word order: 0 = MSB-first, 1 = LSB-first.
- data_val_i  input  1  source word valid.
- ready_o  output  1  block can take a word this cycle.
- ser_data_o  output  1  serial bit.
- ser_data_val_o  output  1  ser_data_o valid.
- ser_last_o  output  1  marks the final serial bit of a word.
- busy_o  output  1  word in shifter or holding buffer.

Behaviour:
- Reset: while srst_i=1, every output is 0 except ready_o. Shifter, buffer and counters clear. In-flight and buffered words are discarded. Inputs are ignored. From the first cycle after reset: ready_o=1, busy_o=0.
- Length decode: len = (data_mod_i==0) ? WIDTH : data_mod_i. If data_mod_i > WIDTH (non-power-of-2 WIDTH), the word is invalid.
- Accept: a handshake occurs when data_val_i && ready_o.
  - Accepted words with len < MIN_LEN, or invalid words, are consumed and dropped. They cause no output and do not change busy_o.
  - data_i, len and lsb_first_i are locked at acceptance. Later input changes have no effect.
- ready_o = !hold_valid (combinational from register state).
- Holding buffer: one entry. The shifter loads from the buffer, or directly from the input when the buffer is empty and the shifter is idle or finishing.
- States:
  - IDLE → SHIFT on load.
  - SHIFT → SHIFT (next word) when the last bit goes out and a word is pending.
  - SHIFT → IDLE otherwise.
  - PARITY state exists only with the optional feature.
- Latency: word accepted at edge N while IDLE → first bit has ser_data_val_o=1 during cycle N+1. All outputs are registered.
- Bit order:
  - MSB-first emits data[WIDTH-1] down to data[WIDTH-len].
  - LSB-first emits data[0] up to data[len-1].
  - Unused bits are never emitted.
- Exactly len cycles with ser_data_val_o=1 per word. ser_last_o=1 only on the final one.
- Back-to-back: if a word is pending (buffer or simultaneous input handshake) when the last bit is emitted, its first bit follows in the very next cycle with no gap.
- Simultaneous events: a handshake in the same cycle the buffer drains into the shifter is legal. The new word goes to the shifter if it is empty, otherwise to the buffer. No word is lost or reordered.
- When ser_data_val_o=0: ser_data_o=0 and ser_last_o=0.
- busy_o = shifter active || hold_valid (registered). It falls in the cycle after the last bit when nothing is pending.
- Bit counter width: $clog2(WIDTH+1). It never wraps past len.

Optional Feature:
- Macro: SER_STREAM_PARITY_EN.
- Defined:
  - After the last data bit, one extra PARITY cycle with ser_data_val_o=1.
  - ser_data_o = even parity (XOR) of the len emitted bits.
  - ser_last_o moves to the parity cycle.
  - Back-to-back gap remains zero after the parity bit.
  - Output is len+1 valid cycles per word.
- Undefined: no PARITY state, no extra cycle, exactly as above.

Test Plan:
- Reset, then data_i=16'hA5C3, data_mod_i=0, lsb_first_i=0, one-cycle valid → 16 valid cycles emitting 1010010111000011, ser_last_o on the 16th, busy_o low one cycle later.
- data_i=16'h00B4, mod=5, lsb_first_i=1 → bits 0,0,1,0,1, then valid drops. Same word with lsb_first_i=0 → bits 0,0,0,0,0.
- Three words presented with data_val_i held high (mods 4, 3, 6): ready_o drops while buffer is full; outputs contiguous 13 valid cycles, ser_last_o at cycles 4, 7, 13.
- mod=2 (below MIN_LEN=3) → handshake completes, no ser_data_val_o, busy_o stays 0.
- srst_i asserted mid-word with one word buffered → next cycle all outputs 0, ready_o=1. A new word then serialises normally with no residue of the old data.
- SER_STREAM_PARITY_EN defined, data_i=16'hF000, mod=4, MSB-first → bits 1,1,1,1 then parity 0 with ser_last_o=1.
